// File: rtl/decode_ereg_pkg.sv
// Shared Y86-64 encodings for the decode stage: instruction codes, register IDs,
// status codes and the static register-ID decode used by decode_ereg.
package decode_ereg_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] NOP_ICODE = INOP;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  localparam logic [3:0] SAOK = 4'h1;
  localparam logic [3:0] SHLT = 4'h2;
  localparam logic [3:0] SADR = 4'h3;
  localparam logic [3:0] SINS = 4'h4;

  typedef struct packed {
    logic [3:0] srcA;
    logic [3:0] srcB;
    logic [3:0] dstE;
    logic [3:0] dstM;
  } regIds_t;

  // Source/destination register IDs implied by each instruction format
  function automatic regIds_t decodeIds(input logic [3:0] icode,
                                        input logic [3:0] rA,
                                        input logic [3:0] rB);
    regIds_t r;
    r = '{srcA: RNONE, srcB: RNONE, dstE: RNONE, dstM: RNONE};
    case (icode)
      IRRMOVQ: begin r.srcA = rA;  r.dstE = rB; end
      IIRMOVQ: begin r.dstE = rB; end
      IRMMOVQ: begin r.srcA = rA;  r.srcB = rB; end
      IMRMOVQ: begin r.srcB = rB;  r.dstM = rA; end
      IOPQ:    begin r.srcA = rA;  r.srcB = rB;  r.dstE = rB; end
      ICALL:   begin r.srcB = RSP; r.dstE = RSP; end
      IRET:    begin r.srcA = RSP; r.srcB = RSP; r.dstE = RSP; end
      IPUSHQ:  begin r.srcA = rA;  r.srcB = RSP; r.dstE = RSP; end
      IPOPQ:   begin r.srcA = RSP; r.srcB = RSP; r.dstE = RSP; r.dstM = rA; end
      default: begin r = '{srcA: RNONE, srcB: RNONE, dstE: RNONE, dstM: RNONE}; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_ereg_fwd_sel.sv
// Priority forwarding mux for one decode operand: valP (optional), then the
// youngest in-flight producer wins, falling back to the register-file read.
module decode_ereg_fwd_sel
  import decode_ereg_pkg::*;
#(
  parameter int WORD     = 64,
  parameter int RW       = 4,
  parameter bit USE_VALP = 1'b0
) (
  input  logic [RW-1:0]   src,
  input  logic            selValP,
  input  logic [WORD-1:0] valP,
  input  logic [RW-1:0]   eDstE,
  input  logic [WORD-1:0] eValE,
  input  logic [RW-1:0]   mDstM,
  input  logic [WORD-1:0] mValM,
  input  logic [RW-1:0]   mDstE,
  input  logic [WORD-1:0] mValE,
  input  logic [RW-1:0]   wDstM,
  input  logic [WORD-1:0] wValM,
  input  logic [RW-1:0]   wDstE,
  input  logic [WORD-1:0] wValE,
  input  logic [WORD-1:0] rval,
  output logic [WORD-1:0] val
);

  // RNONE is a "no register" marker, so it must never alias a pending write
  function automatic logic hit(input logic [RW-1:0] s, input logic [RW-1:0] d);
    return (s != RNONE) && (s == d);
  endfunction

  // Operand selection, first match wins
  always_comb begin
    val = rval;
    if (USE_VALP && selValP) begin
      val = valP;
    end else if (hit(src, eDstE)) begin
      val = eValE;
    end else if (hit(src, mDstM)) begin
      val = mValM;
    end else if (hit(src, mDstE)) begin
      val = mValE;
    end else if (hit(src, wDstM)) begin
      val = wValM;
    end else if (hit(src, wDstE)) begin
      val = wValE;
    end else begin
      val = rval;
    end
  end

endmodule

// File: rtl/decode_ereg.sv
// Y86-64 decode stage with operand forwarding, followed by the D->E pipeline
// register that feeds the execute stage.
module decode_ereg
  import decode_ereg_pkg::*;
#(
  parameter int WORD = 64,
  parameter int RW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      D_stat_i,
  input  logic [3:0]      D_icode_i,
  input  logic [3:0]      D_ifun_i,
  input  logic [RW-1:0]   D_rA_i,
  input  logic [RW-1:0]   D_rB_i,
  input  logic [WORD-1:0] D_valC_i,
  input  logic [WORD-1:0] D_valP_i,
  output logic [RW-1:0]   d_srcA_o,
  output logic [RW-1:0]   d_srcB_o,
  input  logic [WORD-1:0] d_rvalA_i,
  input  logic [WORD-1:0] d_rvalB_i,
  input  logic [RW-1:0]   e_dstE_i,
  input  logic [WORD-1:0] e_valE_i,
  input  logic [RW-1:0]   M_dstE_i,
  input  logic [WORD-1:0] M_valE_i,
  input  logic [RW-1:0]   M_dstM_i,
  input  logic [WORD-1:0] m_valM_i,
  input  logic [RW-1:0]   W_dstE_i,
  input  logic [WORD-1:0] W_valE_i,
  input  logic [RW-1:0]   W_dstM_i,
  input  logic [WORD-1:0] W_valM_i,
  input  logic            E_stall_i,
  input  logic            E_bubble_i,
  output logic [3:0]      E_stat_o,
  output logic [3:0]      E_icode_o,
  output logic [3:0]      E_ifun_o,
  output logic [WORD-1:0] E_valC_o,
  output logic [WORD-1:0] E_valA_o,
  output logic [WORD-1:0] E_valB_o,
  output logic [RW-1:0]   E_dstE_o,
  output logic [RW-1:0]   E_dstM_o,
  output logic [RW-1:0]   E_srcA_o,
  output logic [RW-1:0]   E_srcB_o
);

  regIds_t         ids;
  logic            selValP;
  logic [WORD-1:0] valA;
  logic [WORD-1:0] valB;

  // Register IDs and the valP override come straight from the instruction fields
  always_comb begin
    ids     = decodeIds(D_icode_i, D_rA_i, D_rB_i);
    selValP = (D_icode_i == ICALL) || (D_icode_i == IJXX);
  end

  assign d_srcA_o = ids.srcA;
  assign d_srcB_o = ids.srcB;

  decode_ereg_fwd_sel #(.WORD(WORD), .RW(RW), .USE_VALP(1'b1)) fwdSelA (
    .src     (ids.srcA),
    .selValP (selValP),
    .valP    (D_valP_i),
    .eDstE   (e_dstE_i),
    .eValE   (e_valE_i),
    .mDstM   (M_dstM_i),
    .mValM   (m_valM_i),
    .mDstE   (M_dstE_i),
    .mValE   (M_valE_i),
    .wDstM   (W_dstM_i),
    .wValM   (W_valM_i),
    .wDstE   (W_dstE_i),
    .wValE   (W_valE_i),
    .rval    (d_rvalA_i),
    .val     (valA)
  );

  decode_ereg_fwd_sel #(.WORD(WORD), .RW(RW), .USE_VALP(1'b0)) fwdSelB (
    .src     (ids.srcB),
    .selValP (1'b0),
    .valP    ({WORD{1'b0}}),
    .eDstE   (e_dstE_i),
    .eValE   (e_valE_i),
    .mDstM   (M_dstM_i),
    .mValM   (m_valM_i),
    .mDstE   (M_dstE_i),
    .mValE   (M_valE_i),
    .wDstM   (W_dstM_i),
    .wValM   (W_valM_i),
    .wDstE   (W_dstE_i),
    .wValE   (W_valE_i),
    .rval    (d_rvalB_i),
    .val     (valB)
  );

  // E register: reset and bubble both inject a NOP; stall holds the current contents
  always_ff @(posedge clk) begin
    if (!rst || E_bubble_i) begin
      E_stat_o  <= SAOK;
      E_icode_o <= NOP_ICODE;
      E_ifun_o  <= 4'h0;
      E_valC_o  <= {WORD{1'b0}};
      E_valA_o  <= {WORD{1'b0}};
      E_valB_o  <= {WORD{1'b0}};
      E_dstE_o  <= RNONE;
      E_dstM_o  <= RNONE;
      E_srcA_o  <= RNONE;
      E_srcB_o  <= RNONE;
    end else if (!E_stall_i) begin
      E_stat_o  <= D_stat_i;
      E_icode_o <= D_icode_i;
      E_ifun_o  <= D_ifun_i;
      E_valC_o  <= D_valC_i;
      E_valA_o  <= valA;
      E_valB_o  <= valB;
      E_dstE_o  <= ids.dstE;
      E_dstM_o  <= ids.dstM;
      E_srcA_o  <= ids.srcA;
      E_srcB_o  <= ids.srcB;
    end
  end

endmodule

// File: tb/tb_decode_ereg.sv
// Self-checking bench for decode_ereg: directed scenarios followed by randomized
// traffic, all compared against a rule-level reference model.
module tb_decode_ereg;
  import decode_ereg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  dStat, dIcode, dIfun, dRA, dRB;
  logic [63:0] dValC, dValP, rvalA, rvalB;
  logic [3:0]  eDstE, mDstE, mDstM, wDstE, wDstM;
  logic [63:0] eValE, mValE, mValM, wValE, wValM;
  logic        eStall, eBubble;
  logic [3:0]  srcAO, srcBO;
  logic [3:0]  eStatO, eIcodeO, eIfunO, eDstEO, eDstMO, eSrcAO, eSrcBO;
  logic [63:0] eValCO, eValAO, eValBO;

  decode_ereg dut (
    .clk(clk), .rst(rst),
    .D_stat_i(dStat), .D_icode_i(dIcode), .D_ifun_i(dIfun),
    .D_rA_i(dRA), .D_rB_i(dRB), .D_valC_i(dValC), .D_valP_i(dValP),
    .d_srcA_o(srcAO), .d_srcB_o(srcBO),
    .d_rvalA_i(rvalA), .d_rvalB_i(rvalB),
    .e_dstE_i(eDstE), .e_valE_i(eValE),
    .M_dstE_i(mDstE), .M_valE_i(mValE), .M_dstM_i(mDstM), .m_valM_i(mValM),
    .W_dstE_i(wDstE), .W_valE_i(wValE), .W_dstM_i(wDstM), .W_valM_i(wValM),
    .E_stall_i(eStall), .E_bubble_i(eBubble),
    .E_stat_o(eStatO), .E_icode_o(eIcodeO), .E_ifun_o(eIfunO),
    .E_valC_o(eValCO), .E_valA_o(eValAO), .E_valB_o(eValBO),
    .E_dstE_o(eDstEO), .E_dstM_o(eDstMO), .E_srcA_o(eSrcAO), .E_srcB_o(eSrcBO)
  );

  typedef struct {
    logic [3:0]  stat, icode, ifun;
    logic [63:0] valC, valA, valB;
    logic [3:0]  dstE, dstM, srcA, srcB;
  } eState_t;

  eState_t expE;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] refSrcA(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ}) return ra;
    if (ic inside {IPOPQ, IRET}) return RSP;
    return RNONE;
  endfunction

  function automatic logic [3:0] refSrcB(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {IOPQ, IRMMOVQ, IMRMOVQ}) return rb;
    if (ic inside {IPUSHQ, IPOPQ, ICALL, IRET}) return RSP;
    return RNONE;
  endfunction

  function automatic logic [3:0] refDstE(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {IRRMOVQ, IIRMOVQ, IOPQ}) return rb;
    if (ic inside {IPUSHQ, IPOPQ, ICALL, IRET}) return RSP;
    return RNONE;
  endfunction

  function automatic logic [3:0] refDstM(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {IMRMOVQ, IPOPQ}) return ra;
    return RNONE;
  endfunction

  // Pending writers listed youngest first; the first one naming src supplies the value
  function automatic logic [63:0] refFwd(input logic [3:0] src, input logic [63:0] rval);
    logic [3:0]  d [5];
    logic [63:0] v [5];
    d[0] = eDstE; v[0] = eValE;
    d[1] = mDstM; v[1] = mValM;
    d[2] = mDstE; v[2] = mValE;
    d[3] = wDstM; v[3] = wValM;
    d[4] = wDstE; v[4] = wValE;
    if (src == RNONE) return rval;
    for (int i = 0; i < 5; i++) if (d[i] == src) return v[i];
    return rval;
  endfunction

  function automatic eState_t refNext();
    eState_t n;
    if (!rst || eBubble) begin
      n = '{stat: SAOK, icode: INOP, ifun: 4'h0, valC: 64'h0, valA: 64'h0, valB: 64'h0,
            dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE};
    end else if (eStall) begin
      n = expE;
    end else begin
      n.stat  = dStat;
      n.icode = dIcode;
      n.ifun  = dIfun;
      n.valC  = dValC;
      n.srcA  = refSrcA(dIcode, dRA);
      n.srcB  = refSrcB(dIcode, dRB);
      n.dstE  = refDstE(dIcode, dRB);
      n.dstM  = refDstM(dIcode, dRA);
      n.valA  = (dIcode inside {ICALL, IJXX}) ? dValP : refFwd(n.srcA, rvalA);
      n.valB  = refFwd(n.srcB, rvalB);
    end
    return n;
  endfunction

  task automatic checkE(input string tag);
    check({tag, ".stat"},  eStatO,  expE.stat);
    check({tag, ".icode"}, eIcodeO, expE.icode);
    check({tag, ".ifun"},  eIfunO,  expE.ifun);
    check({tag, ".valC"},  eValCO,  expE.valC);
    check({tag, ".valA"},  eValAO,  expE.valA);
    check({tag, ".valB"},  eValBO,  expE.valB);
    check({tag, ".dstE"},  eDstEO,  expE.dstE);
    check({tag, ".dstM"},  eDstMO,  expE.dstM);
    check({tag, ".srcA"},  eSrcAO,  expE.srcA);
    check({tag, ".srcB"},  eSrcBO,  expE.srcB);
  endtask

  // Inputs settle, decode addresses are checked, then one clock edge and the E register
  task automatic tick(input string tag);
    eState_t nxt;
    #1;
    check({tag, ".d_srcA"}, srcAO, refSrcA(dIcode, dRA));
    check({tag, ".d_srcB"}, srcBO, refSrcB(dIcode, dRB));
    nxt = refNext();
    @(posedge clk);
    expE = nxt;
    #1;
    checkE(tag);
  endtask

  task automatic clearFwd();
    eDstE = RNONE; mDstE = RNONE; mDstM = RNONE; wDstE = RNONE; wDstM = RNONE;
    eValE = 64'h0; mValE = 64'h0; mValM = 64'h0; wValE = 64'h0; wValM = 64'h0;
    rvalA = 64'h0; rvalB = 64'h0;
  endtask

  task automatic setInstr(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [63:0] c, input logic [63:0] p);
    dStat = SAOK; dIcode = ic; dIfun = 4'h0; dRA = ra; dRB = rb; dValC = c; dValP = p;
  endtask

  function automatic logic [3:0] pickReg();
    if ($urandom_range(0, 3) == 0) return RNONE;
    return 4'($urandom_range(0, 5));
  endfunction

  initial begin
    expE = '{stat: SAOK, icode: INOP, ifun: 4'h0, valC: 64'h0, valA: 64'h0, valB: 64'h0,
             dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE};
    eStall = 1'b0; eBubble = 1'b0;
    clearFwd();

    // Reset for two cycles; decode addresses still follow the D inputs
    rst = 1'b0;
    setInstr(IOPQ, 4'h2, 4'h3, 64'h0, 64'h0);
    tick("rst0");
    tick("rst1");
    check("rst_icode", eIcodeO, 64'h1);
    check("rst_dstE", eDstEO, 64'hF);
    check("rst_valA", eValAO, 64'h0);
    check("rst_srcA", srcAO, 64'h2);

    // IRMOVQ into r0
    rst = 1'b1;
    setInstr(IIRMOVQ, RNONE, 4'h0, 64'h13, 64'h0);
    tick("irmovq");
    check("irmovq_srcA", srcAO, 64'hF);
    check("irmovq_srcB", srcBO, 64'hF);
    check("irmovq_dstE", eDstEO, 64'h0);
    check("irmovq_valC", eValCO, 64'h13);

    // Execute beats writeback
    setInstr(IOPQ, 4'h2, 4'h3, 64'h0, 64'h0);
    eDstE = 4'h2; eValE = 64'hAA; wDstE = 4'h2; wValE = 64'hBB; rvalA = 64'hCC;
    tick("fwd_e_w");
    check("fwd_e_w_valA", eValAO, 64'hAA);

    // M_dstM beats M_dstE
    clearFwd();
    setInstr(IOPQ, 4'h3, 4'h3, 64'h0, 64'h0);
    mDstM = 4'h3; mValM = 64'h55; mDstE = 4'h3; mValE = 64'h66;
    tick("fwd_m");
    check("fwd_m_valA", eValAO, 64'h55);
    check("fwd_m_valB", eValBO, 64'h55);

    // CALL uses valP for A and forwards RSP for B
    clearFwd();
    setInstr(ICALL, RNONE, RNONE, 64'h0, 64'h40);
    eDstE = 4'h4; eValE = 64'h77;
    tick("call");
    check("call_valA", eValAO, 64'h40);
    check("call_valB", eValBO, 64'h77);
    check("call_dstE", eDstEO, 64'h4);

    clearFwd();
    setInstr(IPOPQ, RNONE, RNONE, 64'h0, 64'h0);
    tick("popq");
    check("popq_srcA", srcAO, 64'h4);
    check("popq_dstM", eDstMO, 64'hF);

    // An RNONE source never matches an RNONE destination
    clearFwd();
    setInstr(IIRMOVQ, RNONE, 4'h1, 64'h5, 64'h0);
    eDstE = RNONE; eValE = 64'h99; rvalA = 64'h1234;
    tick("rnone");
    check("rnone_valA", eValAO, 64'h1234);

    // Load, then stall twice with changing inputs
    clearFwd();
    setInstr(IRRMOVQ, 4'h1, 4'h2, 64'h0, 64'h0);
    rvalA = 64'hDEAD;
    tick("load");
    eStall = 1'b1;
    setInstr(IOPQ, 4'h3, 4'h5, 64'h7, 64'h9);
    rvalA = 64'h1111;
    tick("stall0");
    tick("stall1");
    check("stall_valA", eValAO, 64'hDEAD);
    check("stall_icode", eIcodeO, 64'h2);
    eBubble = 1'b1;
    tick("stall_bubble");
    check("stall_bubble_icode", eIcodeO, 64'h1);
    eBubble = 1'b0; eStall = 1'b0;
    tick("reload");
    eStall = 1'b1; rst = 1'b0;
    tick("stall_rst");
    check("stall_rst_icode", eIcodeO, 64'h1);
    check("stall_rst_valA", eValAO, 64'h0);
    rst = 1'b1; eStall = 1'b0;

    // Random traffic with register IDs drawn from a small pool to provoke hazards
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 19) != 0);
      eBubble = ($urandom_range(0, 9) == 0);
      eStall  = ($urandom_range(0, 5) == 0);
      dStat   = 4'($urandom_range(1, 4));
      dIcode  = 4'($urandom_range(0, 15));
      dIfun   = 4'($urandom_range(0, 15));
      dRA = pickReg(); dRB = pickReg();
      dValC = {$urandom, $urandom}; dValP = {$urandom, $urandom};
      rvalA = {$urandom, $urandom}; rvalB = {$urandom, $urandom};
      eDstE = pickReg(); mDstE = pickReg(); mDstM = pickReg();
      wDstE = pickReg(); wDstM = pickReg();
      eValE = {$urandom, $urandom}; mValE = {$urandom, $urandom};
      mValM = {$urandom, $urandom}; wValE = {$urandom, $urandom};
      wValM = {$urandom, $urandom};
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
